// File: rtl/lsu_fault_report_pkg.sv
// Shared LSU fault-report types: FSM state, mcause codes and the dc2 fault packet.
package lsu_fault_report_pkg;

  typedef enum logic [0:0] {
    FLT_IDLE   = 1'b0,
    FLT_REPORT = 1'b1
  } lsu_fault_state_e;

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS   = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS   = 4'd7;

  // Address field is sized for the widest supported LSU address; narrower
  // configurations zero-extend, leaving the upper bits constant.
  localparam int unsigned LSU_FAULT_ADDR_MAX_W = 64;

  typedef struct packed {
    logic                            valid;
    logic [3:0]                      cause;
    logic [LSU_FAULT_ADDR_MAX_W-1:0] addr;
  } lsu_fault_pkt_t;

endpackage

// File: rtl/lsu_fault_cause_enc.sv
// dc1 mcause encoder: load/store x misaligned/access, access fault wins.
module lsu_fault_cause_enc
  import lsu_fault_report_pkg::*;
(
  input  logic       store_i,
  input  logic       access_i,
  output logic [3:0] cause_o
);

  // Misaligned is the fallback code; it is only consumed when a fault is present.
  always_comb begin
    cause_o = CAUSE_LD_MISALIGN;
    if (store_i) cause_o = access_i ? CAUSE_ST_ACCESS : CAUSE_ST_MISALIGN;
    else         cause_o = access_i ? CAUSE_LD_ACCESS : CAUSE_LD_MISALIGN;
  end

endmodule

// File: rtl/rvdff.sv
// Reset flop cells: plain (rvdff) and load-enabled (rvdffs), async active-low reset.
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);

  // Register din every edge; clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= '0;
    else        dout <= din;
  end

endmodule

module rvdffs #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] din_sel;

  assign din_sel = en ? din : dout;

  rvdff #(.WIDTH(WIDTH)) u_ff (
    .din   (din_sel),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (dout)
  );

endmodule

// File: rtl/lsu_fault_report.sv
// LSU fault report: captures dc1 address faults into dc2, then holds a stable
// cause/address report for the TLU until acknowledged or flushed.
// Optional taken-fault counter enabled by the macro RV_LSU_FAULT_CNT_EN.
module lsu_fault_report
  import lsu_fault_report_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              lsu_pkt_valid_dc1,
  input  logic              lsu_pkt_store_dc1,
  input  logic              access_fault_dc1,
  input  logic              misaligned_fault_dc1,
  input  logic [ADDR_W-1:0] start_addr_dc1,
  input  logic              lsu_freeze_dc2,
  input  logic              flush_dc2,
  input  logic              flush_dc3,
  input  logic              tlu_fault_ack,
  output logic              lsu_fault_valid_dc3,
  output logic [3:0]        lsu_fault_cause_dc3,
  output logic [ADDR_W-1:0] lsu_fault_addr_dc3,
  output logic              lsu_fault_busy,
`ifdef RV_LSU_FAULT_CNT_EN
  output logic [CNT_W-1:0]  lsu_fault_cnt,
`endif
  input  logic              scan_mode
);

  localparam int RPT_W = 4 + ADDR_W;

  logic             fault_dc1;
  logic [3:0]       cause_dc1;
  lsu_fault_pkt_t   dc2_d, dc2_q;
  logic             dc2_en;
  logic             take_dc2;
  logic             rpt_ld;
  logic [RPT_W-1:0] rpt_d, rpt_q;
  logic [0:0]       state_raw;
  lsu_fault_state_e state_d, state_q;
  logic             unused_bits;

  lsu_fault_cause_enc u_cause_enc (
    .store_i  (lsu_pkt_store_dc1),
    .access_i (access_fault_dc1),
    .cause_o  (cause_dc1)
  );

  // New faults are only accepted while nothing is in flight; upstream stalls on busy.
  assign fault_dc1 = lsu_pkt_valid_dc1 & (access_fault_dc1 | misaligned_fault_dc1)
                   & ~lsu_fault_busy;

  // dc2 next value: flush kills the valid bit; freeze holds unless flushed.
  always_comb begin
    dc2_d.valid = fault_dc1 & ~flush_dc2;
    dc2_d.cause = cause_dc1;
    dc2_d.addr  = LSU_FAULT_ADDR_MAX_W'(start_addr_dc1);
  end

  assign dc2_en = ~lsu_freeze_dc2 | flush_dc2;

  rvdffs #(.WIDTH($bits(lsu_fault_pkt_t))) u_dc2 (
    .din   (dc2_d),
    .en    (dc2_en),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (dc2_q)
  );

  // A dc2 fault moves into the report only when dc2 is free to advance.
  assign take_dc2 = dc2_q.valid & ~flush_dc2 & ~lsu_freeze_dc2 & ~flush_dc3;

  // Report registers load on IDLE entry, or on ack when a follow-on fault is ready.
  assign rpt_ld = take_dc2 & ((state_q == FLT_IDLE) | tlu_fault_ack);
  assign rpt_d  = {dc2_q.cause, dc2_q.addr[ADDR_W-1:0]};

  rvdffs #(.WIDTH(RPT_W)) u_rpt (
    .din   (rpt_d),
    .en    (rpt_ld),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (rpt_q)
  );

  // FSM state register.
  rvdff #(.WIDTH(1)) u_state (
    .din   (state_d),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (state_raw)
  );

  assign state_q = lsu_fault_state_e'(state_raw);

  // FSM next state: report on a taken dc2 fault; leave on ack or dc3 flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FLT_IDLE:   if (take_dc2) state_d = FLT_REPORT;
      FLT_REPORT: if (tlu_fault_ack | flush_dc3) state_d = take_dc2 ? FLT_REPORT : FLT_IDLE;
    endcase
  end

  // FSM outputs: report valid in REPORT; busy while anything is pending.
  always_comb begin
    lsu_fault_valid_dc3 = (state_q == FLT_REPORT);
    lsu_fault_busy      = (state_q == FLT_REPORT) | dc2_q.valid;
  end

  assign lsu_fault_cause_dc3 = rpt_q[RPT_W-1 -: 4];
  assign lsu_fault_addr_dc3  = rpt_q[ADDR_W-1:0];

`ifdef RV_LSU_FAULT_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count reports taken by the TLU (ack with or without flush), saturating.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == FLT_REPORT) && tlu_fault_ack && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  rvdff #(.WIDTH(CNT_W)) u_cnt (
    .din   (cnt_d),
    .clk   (clk),
    .rst_l (rst_l),
    .dout  (cnt_q)
  );

  assign lsu_fault_cnt = cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  // scan_mode has no functional effect; upper address bits are constant zero.
  assign unused_bits = ^{scan_mode, dc2_q.addr};

endmodule

// File: tb/tb_lsu_fault_report.sv
// Directed bench for lsu_fault_report: vector table plus multi-cycle sequences.
module tb_lsu_fault_report;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_l;
  logic              pkt_valid, pkt_store, acc_flt, mis_flt;
  logic [ADDR_W-1:0] start_addr;
  logic              freeze, flush2, flush3, ack;
  logic              fvalid;
  logic [3:0]        fcause;
  logic [ADDR_W-1:0] faddr;
  logic              busy;
  logic              scan_mode;
`ifdef RV_LSU_FAULT_CNT_EN
  logic [CNT_W-1:0]  cnt;
`endif

  lsu_fault_report #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst_l                (rst_l),
    .lsu_pkt_valid_dc1    (pkt_valid),
    .lsu_pkt_store_dc1    (pkt_store),
    .access_fault_dc1     (acc_flt),
    .misaligned_fault_dc1 (mis_flt),
    .start_addr_dc1       (start_addr),
    .lsu_freeze_dc2       (freeze),
    .flush_dc2            (flush2),
    .flush_dc3            (flush3),
    .tlu_fault_ack        (ack),
    .lsu_fault_valid_dc3  (fvalid),
    .lsu_fault_cause_dc3  (fcause),
    .lsu_fault_addr_dc3   (faddr),
    .lsu_fault_busy       (busy),
`ifdef RV_LSU_FAULT_CNT_EN
    .lsu_fault_cnt        (cnt),
`endif
    .scan_mode            (scan_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  typedef struct {
    logic        pv;
    logic        st;
    logic        acc;
    logic        mis;
    logic [31:0] addr;
    logic        exp_v;
    logic [3:0]  exp_cause;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic pv, input logic st, input logic acc, input logic mis,
                         input logic [31:0] a);
    pkt_valid  = pv;
    pkt_store  = st;
    acc_flt    = acc;
    mis_flt    = mis;
    start_addr = a;
  endtask

  task automatic clear_pkt;
    present(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic bump_cnt;
    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
  endtask

  task automatic ack_report;
    ack = 1'b1;
    tick;
    ack = 1'b0;
    bump_cnt;
  endtask

  // Fault in one cycle, then two edges until the report is visible.
  task automatic enter_report(input logic st, input logic acc, input logic mis, input logic [31:0] a);
    present(1'b1, st, acc, mis, a);
    tick;
    clear_pkt;
    tick;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0;
    clear_pkt;
    freeze = 1'b0; flush2 = 1'b0; flush3 = 1'b0; ack = 1'b0; scan_mode = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0003, 1'b1, 4'd4};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 4'd5};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h1234_5677, 1'b1, 4'd6};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 4'd7};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hF004_0001, 1'b1, 4'd7};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 4'd5};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b0, 4'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBBBB_0000, 1'b0, 4'd0};

    // Reset state
    tick;
    check("rst_valid", 64'(fvalid), 64'd0);
    check("rst_busy",  64'(busy),   64'd0);
    check("rst_cause", 64'(fcause), 64'd0);
    check("rst_addr",  64'(faddr),  64'd0);
`ifdef RV_LSU_FAULT_CNT_EN
    check("rst_cnt", 64'(cnt), 64'd0);
`endif
    rst_l = 1'b1;
    tick;

    // Table-driven encode / latency / ack
    for (int i = 0; i < 8; i++) begin
      present(vecs[i].pv, vecs[i].st, vecs[i].acc, vecs[i].mis, vecs[i].addr);
      tick;
      clear_pkt;
      check($sformatf("v%0d_busy_dc2", i), 64'(busy), 64'(vecs[i].exp_v));
      check($sformatf("v%0d_valid_n1", i), 64'(fvalid), 64'd0);
      tick;
      check($sformatf("v%0d_valid_n2", i), 64'(fvalid), 64'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        check($sformatf("v%0d_cause", i), 64'(fcause), 64'(vecs[i].exp_cause));
        check($sformatf("v%0d_addr", i),  64'(faddr),  64'(vecs[i].addr));
        ack_report;
        check($sformatf("v%0d_ack_valid", i), 64'(fvalid), 64'd0);
        check($sformatf("v%0d_ack_busy", i),  64'(busy),   64'd0);
      end else begin
        tick;
        check($sformatf("v%0d_still_idle", i), 64'(fvalid), 64'd0);
      end
    end
`ifdef RV_LSU_FAULT_CNT_EN
    check("cnt_after_table", 64'(cnt), 64'(exp_cnt));
`endif

    // Load misaligned: valid two cycles after dc1, ack one cycle later clears
    enter_report(1'b0, 1'b0, 1'b1, 32'h8000_0003);
    check("lat_valid_n2", 64'(fvalid), 64'd1);
    check("lat_cause",    64'(fcause), 64'd4);
    tick;
    check("lat_valid_n3", 64'(fvalid), 64'd1);
    tick;
    check("lat_valid_n4", 64'(fvalid), 64'd1);
    ack_report;
    check("lat_valid_n5", 64'(fvalid), 64'd0);

    // Stability without ack; a fault offered while busy is dropped
    enter_report(1'b1, 1'b1, 1'b1, 32'hF004_0001);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stab%0d_valid", k), 64'(fvalid), 64'd1);
      check($sformatf("stab%0d_cause", k), 64'(fcause), 64'd7);
      check($sformatf("stab%0d_addr", k),  64'(faddr),  64'hF004_0001);
      if (k == 1) present(1'b1, 1'b0, 1'b1, 1'b0, 32'h1111_1111);
      else        clear_pkt;
      tick;
    end
    ack_report;
    check("drop_valid_ack", 64'(fvalid), 64'd0);
    tick;
    tick;
    check("drop_valid_late", 64'(fvalid), 64'd0);
    check("drop_busy_late",  64'(busy),   64'd0);

    // flush_dc2 one cycle after the fault kills it
    present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2000);
    tick;
    clear_pkt;
    flush2 = 1'b1;
    tick;
    flush2 = 1'b0;
    check("fl2_busy",   64'(busy),   64'd0);
    check("fl2_valid1", 64'(fvalid), 64'd0);
    tick;
    check("fl2_valid2", 64'(fvalid), 64'd0);

    // flush_dc3 during REPORT: idle next cycle, not counted
    enter_report(1'b1, 1'b0, 1'b1, 32'h0000_3000);
    check("fl3_valid_pre", 64'(fvalid), 64'd1);
    flush3 = 1'b1;
    tick;
    flush3 = 1'b0;
    check("fl3_valid", 64'(fvalid), 64'd0);
    check("fl3_busy",  64'(busy),   64'd0);
`ifdef RV_LSU_FAULT_CNT_EN
    check("fl3_cnt", 64'(cnt), 64'(exp_cnt));
`endif

    // Freeze over three cycles delays the report and keeps the original address
    present(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_0002);
    tick;
    freeze = 1'b1;
    present(1'b1, 1'b1, 1'b1, 1'b0, 32'h5555_5554);
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("frz%0d_valid", k), 64'(fvalid), 64'd0);
      check($sformatf("frz%0d_busy", k),  64'(busy),   64'd1);
    end
    freeze = 1'b0;
    clear_pkt;
    tick;
    check("frz_valid", 64'(fvalid), 64'd1);
    check("frz_cause", 64'(fcause), 64'd4);
    check("frz_addr",  64'(faddr),  64'h4000_0002);
    ack_report;

    // Ack together with flush_dc3: idle, and counted as taken
    enter_report(1'b1, 1'b1, 1'b0, 32'h0000_6000);
    ack = 1'b1;
    flush3 = 1'b1;
    tick;
    ack = 1'b0;
    flush3 = 1'b0;
    bump_cnt;
    check("ackfl_valid", 64'(fvalid), 64'd0);
`ifdef RV_LSU_FAULT_CNT_EN
    check("ackfl_cnt", 64'(cnt), 64'(exp_cnt));
`endif

    // Ack while idle is ignored
    ack = 1'b1;
    tick;
    ack = 1'b0;
    check("ackidle_valid", 64'(fvalid), 64'd0);
    check("ackidle_busy",  64'(busy),   64'd0);
`ifdef RV_LSU_FAULT_CNT_EN
    check("ackidle_cnt", 64'(cnt), 64'(exp_cnt));
`endif

    // Fault straight after an ack is captured normally
    enter_report(1'b0, 1'b1, 1'b0, 32'h0000_7770);
    ack_report;
    enter_report(1'b0, 1'b0, 1'b1, 32'h0000_7771);
    check("b2b_valid", 64'(fvalid), 64'd1);
    check("b2b_addr",  64'(faddr),  64'h0000_7771);
    ack_report;

    // Asynchronous reset mid-REPORT
    enter_report(1'b1, 1'b1, 1'b0, 32'h0000_7000);
    check("arst_pre_valid", 64'(fvalid), 64'd1);
    #3;
    rst_l = 1'b0;
    #1;
    exp_cnt = 0;
    check("arst_valid", 64'(fvalid), 64'd0);
    check("arst_busy",  64'(busy),   64'd0);
    check("arst_cause", 64'(fcause), 64'd0);
    check("arst_addr",  64'(faddr),  64'd0);
`ifdef RV_LSU_FAULT_CNT_EN
    check("arst_cnt", 64'(cnt), 64'd0);
`endif
    tick;
    rst_l = 1'b1;
    tick;
    check("arst_post_valid", 64'(fvalid), 64'd0);

`ifdef RV_LSU_FAULT_CNT_EN
    // Counter saturation after 2^CNT_W+3 acked faults
    for (int n = 0; n < (1 << CNT_W) + 3; n++) begin
      enter_report(1'b0, 1'b0, 1'b1, 32'(n));
      ack_report;
      if (n == 4) check("cnt_mid", 64'(cnt), 64'd5);
    end
    check("cnt_sat", 64'(cnt), 64'((1 << CNT_W) - 1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_fault_report.md
LSU_FAULT_REPORT -- requirements
Module: lsu_fault_report

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, fault address width.
REQ-002 SHALL have parameter CNT_W, default 16, fault counter width (used only under RV_LSU_FAULT_CNT_EN).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_l.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- rst_l  in  1  asynchronous active-low reset.
- lsu_pkt_valid_dc1  in  1  valid non-DMA LSU packet in dc1.
- lsu_pkt_store_dc1  in  1  packet is a store (0 = load).
- access_fault_dc1  in  1  access fault from address check.
- misaligned_fault_dc1  in  1  misaligned fault from address check.
- start_addr_dc1  in  ADDR_W  faulting start address.
- lsu_freeze_dc2  in  1  hold the dc2 stage.
- flush_dc2  in  1  kill the dc2 stage.
- flush_dc3  in  1  kill the dc3 stage and any pending report.
- tlu_fault_ack  in  1  TLU has taken the report.
- lsu_fault_valid_dc3  out  1  fault report valid.
- lsu_fault_cause_dc3  out  4  mcause code.
- lsu_fault_addr_dc3  out  ADDR_W  mtval value.
- lsu_fault_busy  out  1  report pending; stall new LSU issue.
- lsu_fault_cnt  out  CNT_W  taken-fault count (present only with the macro).
- scan_mode  in  1  scan enable; no functional effect.

Function
REQ-005 dc1 capture SHALL be: fault_dc1 = lsu_pkt_valid_dc1 & (access_fault_dc1 | misaligned_fault_dc1) & ~lsu_fault_busy.
REQ-006 Cause SHALL be encoded in dc1 as follows; access fault wins when both faults are set:
- Load misaligned = 4.
- Load access = 5.
- Store misaligned = 6.
- Store access = 7.
REQ-007 The dc2 register SHALL load {fault_dc1, cause, start_addr_dc1} each cycle unless lsu_freeze_dc2 is set, in which case it SHALL hold.
REQ-008 flush_dc2 SHALL clear the dc2 valid bit at the next edge, and SHALL take priority over both freeze and load.
REQ-009 The FSM SHALL have two states, IDLE and REPORT.
REQ-010 IDLE -> REPORT SHALL occur when dc2 valid & ~flush_dc2 & ~lsu_freeze_dc2 & ~flush_dc3; on this edge cause and address are registered into the report registers.
REQ-011 REPORT -> IDLE SHALL occur on tlu_fault_ack or flush_dc3.
REQ-012 lsu_fault_valid_dc3 SHALL equal (state == REPORT).
REQ-013 Cause and address SHALL be held stable for the whole REPORT state.
REQ-014 lsu_fault_busy SHALL equal (state == REPORT) | dc2 valid.
REQ-015 Latency: a fault in dc1 at cycle N with no freeze or flush SHALL give lsu_fault_valid_dc3 = 1 from cycle N+2.
REQ-016 When ack and flush_dc3 arrive in the same cycle, the state SHALL go to IDLE and the report SHALL count as taken.
REQ-017 Faults presented while lsu_fault_busy = 1 SHALL be dropped; upstream stalls issue on busy.
REQ-018 When ack is given in cycle M and a dc2 fault is valid, REPORT SHALL be re-entered at M+1; there is no back-to-back loss.
REQ-019 Ack while IDLE SHALL be ignored.

Reset
REQ-020 rst_l low SHALL asynchronously force the following, effective mid-operation with no completion of a pending report:
- state = IDLE and dc2 valid = 0.
- lsu_fault_valid_dc3 = 0 and lsu_fault_busy = 0.
- lsu_fault_cause_dc3 = 0 and lsu_fault_addr_dc3 = 0.
- lsu_fault_cnt = 0.

Configuration
REQ-021 Macro RV_LSU_FAULT_CNT_EN defined: lsu_fault_cnt SHALL increment by 1 on each REPORT state with tlu_fault_ack = 1, and SHALL saturate at all-ones.
REQ-022 RV_LSU_FAULT_CNT_EN undefined: the port and counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-023 The shared LSU package SHALL hold:
- The fault-state enum (IDLE, REPORT).
- The four cause localparams (4, 5, 6, 7).
- The packed struct {valid, cause[3:0], addr}.
REQ-024 A single sub-module lsu_fault_cause_enc (combinational dc1 cause encode) SHALL be used; all flops SHALL be rvdff-family cells.

Verification
REQ-025 Load with misaligned_fault_dc1 = 1 and addr 0x8000_0003 at cycle 10 -> valid at 12, cause 4, addr 0x8000_0003; ack at 14 -> valid 0 at 15.
REQ-026 Store with both faults = 1 and addr 0xF004_0001 -> cause 7; cause and addr stable for 5 cycles without ack.
REQ-027 Fault at cycle 10 with flush_dc2 at 11 -> valid never asserts; separately, flush_dc3 during REPORT -> IDLE next cycle and the counter is unchanged.
REQ-028 lsu_freeze_dc2 held for cycles 11-13 after a cycle-10 fault -> valid at 15 with the original address.
REQ-029 rst_l dropped mid-REPORT -> all outputs 0 immediately (asynchronously); with RV_LSU_FAULT_CNT_EN, 2^CNT_W+3 acked faults -> lsu_fault_cnt = all-ones.
